// File: rtl/arb4_rr.sv
// Four-requester arbiter with registered one-hot grant held until the owner releases.
// Optional hold-limit with forced release is enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate on the next edge if any request is high
// GRANT | gnt held for gnt_idx until its request drops (or hold limit expires)
module arb4_rr #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_v,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] idx_nxt;
    logic       v_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] win, cand;
    logic       win_v;
    logic       hold_expired;
    logic       grant_issue;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win   = 2'd0;
        cand  = 2'd0;
        win_v = |req;
        if (PRIO_MODE == 1) begin
            for (int k = 0; k < 4; k++) begin
                if (req[k]) win = k[1:0];
            end
        end else begin
            for (int k = 4; k >= 1; k--) begin
                cand = ptr + k[1:0];
                if (req[cand]) win = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign hold_expired = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == GRANT) && req[gnt_idx] && hold_expired;
            if (grant_issue)
                hold_cnt <= 8'd0;
            else if (state == GRANT)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_hold;
    assign unused_hold  = ^HOLD_LAST;
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        v_nxt       = gnt_v;
        ptr_nxt     = ptr;
        grant_issue = 1'b0;
        case (state)
            IDLE: begin
                if (win_v) begin
                    state_nxt   = GRANT;
                    gnt_nxt     = 4'b0001 << win;
                    idx_nxt     = win;
                    v_nxt       = 1'b1;
                    ptr_nxt     = win;
                    grant_issue = 1'b1;
                end
            end
            GRANT: begin
                // A dropped request and an expired hold both release the same way.
                if (!req[gnt_idx] || hold_expired) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    idx_nxt   = 2'd0;
                    v_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                idx_nxt   = 2'd0;
                v_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_v   <= 1'b0;
            ptr     <= 2'd3;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_v   <= v_nxt;
            ptr     <= ptr_nxt;
        end
    end

endmodule

// File: doc/arb4_rr.md
Name: arb4_rr

Overview:
- Four-requester arbiter that shares one downstream resource (bus, encoder input, memory port) between four requesters.
- Selection logic is a priority encoder whose priority order rotates (round-robin) or is fixed (index 3 highest).
- Grant is registered and held until the owner drops its request.
- Outputs one-hot grant, binary owner index and a valid flag.

Parameters:
- PRIO_MODE, 0, selection order: 0 = round-robin from last owner, 1 = fixed priority (req[3] > req[2] > req[1] > req[0]).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  4  request lines, one per requester; held high for the whole transaction
- gnt  output  4  registered one-hot grant; all-zero when idle
- gnt_idx  output  2  binary index of current owner; 0 when idle
- gnt_v  output  1  1 while any grant is active (OR of gnt)
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=4'b0000, gnt_idx=2'd0, gnt_v=0, timeout=0, last-owner pointer ptr=2'd3, hold counter=0.
- States: IDLE, GRANT. All outputs registered; no combinational path from req to outputs.
- IDLE: on each edge, if req != 0, select a winner W and go to GRANT with gnt=onehot(W), gnt_idx=W, gnt_v=1. Latency: req seen at edge N gives gnt visible after edge N. If req == 0, stay in IDLE.
- Round-robin selection (PRIO_MODE=0): search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); the first asserted request wins. ptr is updated to W when the grant is issued. With ptr=3 after reset, req[0] has top priority.
- Fixed selection (PRIO_MODE=1): W is the highest asserted index. ptr is still updated but does not affect selection.
- GRANT: while req[owner]=1, hold gnt/gnt_idx unchanged. Requests from other requesters are ignored, with no preemption.
- Release: at an edge where req[owner]=0, go to IDLE with gnt=0, gnt_idx=0, gnt_v=0.
- There is exactly one idle cycle between consecutive grants. Arbitration occurs on the edge after the release edge.
- Requests that drop before being granted are simply not considered; there is no request latching.
- The owner's request rising again after release competes normally. In round-robin it is lowest priority (ptr=owner).
- Simultaneous release of the owner and new requests: release takes priority; the new requests are arbitrated one cycle later.
- Reset mid-grant: outputs are cleared immediately (async) and ptr returns to 3.
- Invariant: gnt is always one-hot or zero; gnt_v == |gnt; gnt_idx matches the set bit of gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant issue and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD-1 with req[owner] still 1, the next edge forces the transition to IDLE: gnt=0, gnt_v=0, timeout=1 for one cycle.
  - The owner must drop and re-raise req, or simply keep it high, to re-compete. In round-robin it now has lowest priority.
  - Total grant length is therefore at most MAX_HOLD cycles.
- Undefined: no counter logic; timeout tied to 0; grants are held indefinitely.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_idx=0, gnt_v=0, timeout=0 throughout.
- PRIO_MODE=0: req=4'b1111 held; each owner drops its req for 1 cycle after 3 cycles of grant, then re-raises it -> grant order 0,1,2,3,0. Each grant lasts 3 cycles with a 1-cycle gap between grants.
- PRIO_MODE=1: req=4'b0110 -> gnt=4'b0100, gnt_idx=2. Raise req[3] mid-grant -> no change until req[2] drops. Next grant is gnt=4'b1000, gnt_idx=3.
- Single requester: req=4'b0010 at edge N -> gnt=4'b0010, gnt_idx=1, gnt_v=1 after edge N. Drop req[1] -> gnt=0 after the next edge.
- Assert rst asynchronously while gnt=4'b0100 -> all outputs 0 immediately. After rst deasserts with req=4'b1111, the first grant goes to requester 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> gnt=4'b0001 for 4 cycles, then timeout=1 with gnt=0 for 1 cycle, then gnt=4'b0010 for 4 cycles, repeating.
